// File: rtl/tinyqv_intc.sv
// TinyQV interrupt controller: per-line edge/level capture, fixed priority, mcause latch and
// vectored mtvec, with nibble-serial CSR access stepped by the core's sub-cycle counter.
module tinyqv_intc #(
   parameter int unsigned NUM_IRQ     = 4,
   parameter logic [15:0] EDGE_RESET  = 16'h0003,
   parameter logic [27:0] MTVEC_RESET = 28'h0000004
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [2:0]         counter,
   input  logic [11:0]        csr_addr,
   input  logic [1:0]         csr_op,
   input  logic [3:0]         csr_wdata,
   output logic [3:0]         csr_rdata,
   output logic               csr_hit,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               timer_irq,
   input  logic               global_ie,
   input  logic               take_interrupt,
   output logic               interrupt_pending,
   output logic [4:0]         mcause_code,
   output logic [27:0]        trap_vector
);

   localparam logic [11:0] AddrMie   = 12'h304;
   localparam logic [11:0] AddrMtvec = 12'h305;
   localparam logic [11:0] AddrMip   = 12'h344;
   localparam logic [11:0] AddrMtrig = 12'h7C0;

   logic [NUM_IRQ-1:0] irq_q, edge_latch, mtrig, mie_ext;
   logic [NUM_IRQ-1:0] edge_latch_d, mtrig_d, mie_ext_d;
   logic [NUM_IRQ-1:0] irq_rise, mip_ext;
   logic               mie_timer, mie_timer_d;
   logic [27:0]        mtvec, mtvec_d, vec_base;
   logic [4:0]         cause_d;
   logic [31:0]        mie_word, mip_word, mtrig_word, rd_word, enabled;
   logic               hit_mie, hit_mtvec, hit_mip, hit_mtrig, wr;

   function automatic logic upd_bit(input logic old, input logic w, input logic [1:0] op);
      case (op)
         2'b01:   upd_bit = w;
         2'b10:   upd_bit = old | w;
         2'b11:   upd_bit = old & ~w;
         default: upd_bit = old;
      endcase
   endfunction

   assign hit_mie   = (csr_addr == AddrMie);
   assign hit_mtvec = (csr_addr == AddrMtvec);
   assign hit_mip   = (csr_addr == AddrMip);
   assign hit_mtrig = (csr_addr == AddrMtrig);
   assign csr_hit   = hit_mie | hit_mtvec | hit_mip | hit_mtrig;
   assign wr        = (csr_op != 2'b00);

   assign irq_rise = irq_in & ~irq_q;
   assign mip_ext  = (mtrig & edge_latch) | (~mtrig & irq_q);

   always_comb begin
      mie_word                    = '0;
      mie_word[7]                 = mie_timer;
      mie_word[16 +: NUM_IRQ]     = mie_ext;
      mip_word                    = '0;
      mip_word[7]                 = timer_irq;
      mip_word[16 +: NUM_IRQ]     = mip_ext;
      mtrig_word                  = '0;
      mtrig_word[NUM_IRQ-1:0]     = mtrig;
      rd_word                     = '0;
      if (hit_mie)        rd_word = mie_word;
      else if (hit_mtvec) rd_word = {4'h0, mtvec};
      else if (hit_mip)   rd_word = mip_word;
      else if (hit_mtrig) rd_word = mtrig_word;
   end

   assign csr_rdata = rd_word[{counter, 2'b00} +: 4];

   assign enabled           = mip_word & mie_word;
   assign interrupt_pending = global_ie & (|enabled);

   always_comb begin
      cause_d = 5'd16;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (enabled[16+i]) cause_d = 5'(16 + i);
      end
      if (enabled[7]) cause_d = 5'd7;
   end

   always_comb begin
      mie_timer_d  = mie_timer;
      mie_ext_d    = mie_ext;
      edge_latch_d = edge_latch;
      mtrig_d      = mtrig;
      mtvec_d      = mtvec;
      if (wr && hit_mie && counter == 3'd1) begin
         mie_timer_d = upd_bit(mie_timer, csr_wdata[3], csr_op);
      end
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
         if (wr && counter == 3'(4 + i / 4)) begin
            if (hit_mie) mie_ext_d[i] = upd_bit(mie_ext[i], csr_wdata[i % 4], csr_op);
            if (hit_mip && mtrig[i]) begin
               edge_latch_d[i] = upd_bit(edge_latch[i], csr_wdata[i % 4], csr_op);
            end
         end
         if (wr && hit_mtrig && counter == 3'(i / 4)) begin
            mtrig_d[i] = upd_bit(mtrig[i], csr_wdata[i % 4], csr_op);
         end
      end
      for (int b = 0; b < 28; b++) begin
         if (wr && hit_mtvec && counter == 3'(b / 4)) begin
            mtvec_d[b] = upd_bit(mtvec[b], csr_wdata[b % 4], csr_op);
         end
      end
      // A new edge beats a CSR clear; a line switched to level drops its latch.
      edge_latch_d = (edge_latch_d | (mtrig & irq_rise)) & mtrig_d;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         irq_q       <= '0;
         edge_latch  <= '0;
         mtrig       <= EDGE_RESET[NUM_IRQ-1:0];
         mie_ext     <= '0;
         mie_timer   <= 1'b0;
         mtvec       <= MTVEC_RESET;
         mcause_code <= '0;
      end else begin
         irq_q      <= irq_in;
         edge_latch <= edge_latch_d;
         mtrig      <= mtrig_d;
         mie_ext    <= mie_ext_d;
         mie_timer  <= mie_timer_d;
         mtvec      <= mtvec_d;
         if (take_interrupt && counter == 3'd0) mcause_code <= cause_d;
      end
   end

   assign vec_base = {mtvec[27:2], 2'b00};

   always_comb begin
      trap_vector = vec_base;
      if (mtvec[1:0] == 2'b01) trap_vector = vec_base + {21'd0, mcause_code, 2'b00};
   end

endmodule

// File: tb/tb_tinyqv_intc.sv
// Directed self-checking bench for tinyqv_intc (NUM_IRQ=4): CSR nibble access, edge/level
// capture, priority, mcause latching, trap vector arithmetic and mid-access reset.
module tb_tinyqv_intc;

   logic        clk = 1'b0;
   logic        rstn;
   logic [2:0]  counter;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic [3:0]  csr_wdata;
   logic [3:0]  csr_rdata;
   logic        csr_hit;
   logic [3:0]  irq_in;
   logic        timer_irq;
   logic        global_ie;
   logic        take_interrupt;
   logic        interrupt_pending;
   logic [4:0]  mcause_code;
   logic [27:0] trap_vector;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] rd;

   tinyqv_intc #(
      .NUM_IRQ    (4),
      .EDGE_RESET (16'h0003),
      .MTVEC_RESET(28'h0000004)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .counter          (counter),
      .csr_addr         (csr_addr),
      .csr_op           (csr_op),
      .csr_wdata        (csr_wdata),
      .csr_rdata        (csr_rdata),
      .csr_hit          (csr_hit),
      .irq_in           (irq_in),
      .timer_irq        (timer_irq),
      .global_ie        (global_ie),
      .take_interrupt   (take_interrupt),
      .interrupt_pending(interrupt_pending),
      .mcause_code      (mcause_code),
      .trap_vector      (trap_vector)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; the core's counter advances every clock.
   task automatic step();
      @(posedge clk);
      #1;
      counter = counter + 3'd1;
   endtask

   task automatic align();
      while (counter != 3'd0) step();
   endtask

   task automatic csr_xfer(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd,
                           input int edge_k, input int rst_k, output logic [31:0] rdv);
      align();
      rdv = '0;
      for (int k = 0; k < 8; k++) begin
         csr_addr  = addr;
         csr_op    = op;
         csr_wdata = wd[k*4 +: 4];
         if (k == edge_k) irq_in[0] = 1'b1;
         if (k == rst_k) rstn = 1'b0;
         #1;
         rdv[k*4 +: 4] = csr_rdata;
         step();
      end
      csr_op   = 2'b00;
      csr_addr = 12'h000;
      rstn     = 1'b1;
      #1;
   endtask

   task automatic csr_wr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd);
      logic [31:0] dummy;
      csr_xfer(addr, op, wd, -1, -1, dummy);
   endtask

   task automatic csr_rd(input logic [11:0] addr, output logic [31:0] rdv);
      csr_xfer(addr, 2'b00, 32'h0, -1, -1, rdv);
   endtask

   task automatic take_irq();
      align();
      take_interrupt = 1'b1;
      step();
      take_interrupt = 1'b0;
      #1;
   endtask

   initial begin
      logic [11:0] hit_addrs [4];
      hit_addrs = '{12'h304, 12'h305, 12'h344, 12'h7C0};
      rstn = 1'b0; counter = 3'd0; csr_addr = 12'h000; csr_op = 2'b00; csr_wdata = 4'h0;
      irq_in = 4'h0; timer_irq = 1'b0; global_ie = 1'b0; take_interrupt = 1'b0;
      step(); step(); step();
      rstn = 1'b1;
      #1;

      // Reset state
      check_eq("rst_pending", 32'(interrupt_pending), 32'h0);
      check_eq("rst_mcause", 32'(mcause_code), 32'h0);
      check_eq("rst_trapvec", 32'(trap_vector), 32'h0000004);
      check_eq("idle_rdata", 32'(csr_rdata), 32'h0);
      check_eq("idle_hit", 32'(csr_hit), 32'h0);
      for (int a = 0; a < 4; a++) begin
         csr_addr = hit_addrs[a];
         #1;
         check_eq("addr_hit", 32'(csr_hit), 32'h1);
      end
      csr_addr = 12'h300;
      #1;
      check_eq("unknown_hit", 32'(csr_hit), 32'h0);
      csr_addr = 12'h000;
      csr_rd(12'h305, rd); check_eq("rst_mtvec", rd, 32'h00000004);
      csr_rd(12'h7C0, rd); check_eq("rst_mtrig", rd, 32'h00000003);
      csr_rd(12'h304, rd); check_eq("rst_mie", rd, 32'h0);
      csr_rd(12'h344, rd); check_eq("rst_mip", rd, 32'h0);
      csr_xfer(12'h300, 2'b01, 32'hFFFFFFFF, -1, -1, rd); check_eq("unknown_rd", rd, 32'h0);

      // mie masking and edge line 0
      csr_wr(12'h304, 2'b01, 32'hFFFFFFFF);
      csr_rd(12'h304, rd); check_eq("mie_mask", rd, 32'h000F0080);
      csr_wr(12'h304, 2'b01, 32'h00010080);
      csr_rd(12'h304, rd); check_eq("mie_write", rd, 32'h00010080);
      global_ie = 1'b1;
      step();
      irq_in[0] = 1'b1;
      #1;
      check_eq("edge_before", 32'(interrupt_pending), 32'h0);
      step();
      irq_in[0] = 1'b0;
      #1;
      check_eq("edge_pending", 32'(interrupt_pending), 32'h1);
      step();
      check_eq("edge_held", 32'(interrupt_pending), 32'h1);
      global_ie = 1'b0;
      #1;
      check_eq("gie_gate", 32'(interrupt_pending), 32'h0);
      global_ie = 1'b1;
      csr_rd(12'h344, rd); check_eq("mip_edge", rd, 32'h00010000);
      csr_wr(12'h344, 2'b11, 32'h00010000);
      check_eq("edge_cleared", 32'(interrupt_pending), 32'h0);

      // Level line 2
      csr_wr(12'h304, 2'b10, 32'h00040000);
      csr_rd(12'h304, rd); check_eq("mie_set", rd, 32'h00050080);
      irq_in[2] = 1'b1;
      #1;
      check_eq("level_before", 32'(interrupt_pending), 32'h0);
      step();
      check_eq("level_pending", 32'(interrupt_pending), 32'h1);
      csr_wr(12'h344, 2'b10, 32'h00040000);
      csr_wr(12'h344, 2'b11, 32'h00040000);
      csr_rd(12'h344, rd); check_eq("mip_level", rd, 32'h00040000);
      irq_in[2] = 1'b0;
      step();
      check_eq("level_drop", 32'(interrupt_pending), 32'h0);

      // Priority and cause
      timer_irq = 1'b1;
      irq_in[1] = 1'b1;
      csr_wr(12'h304, 2'b10, 32'h00020000);
      take_irq(); check_eq("cause_timer", 32'(mcause_code), 32'd7);
      csr_wr(12'h304, 2'b11, 32'h00000080);
      take_irq(); check_eq("cause_ext1", 32'(mcause_code), 32'd17);
      check_eq("trap_direct4", 32'(trap_vector), 32'h0000004);
      irq_in[1] = 1'b0;
      csr_wr(12'h344, 2'b11, 32'h00020000);
      check_eq("none_pending", 32'(interrupt_pending), 32'h0);
      take_irq(); check_eq("cause_none", 32'(mcause_code), 32'd16);

      // Trap vector
      csr_wr(12'h305, 2'b01, 32'h00001001);
      check_eq("vec_c16", 32'(trap_vector), 32'h0001040);
      csr_wr(12'h344, 2'b10, 32'h00020000);
      take_irq(); check_eq("cause_sw17", 32'(mcause_code), 32'd17);
      check_eq("vec_c17", 32'(trap_vector), 32'h0001044);
      csr_wr(12'h305, 2'b01, 32'h00001000);
      check_eq("direct_1000", 32'(trap_vector), 32'h0001000);
      csr_wr(12'h305, 2'b01, 32'h00001003);
      check_eq("mode3_direct", 32'(trap_vector), 32'h0001000);
      csr_wr(12'h305, 2'b01, 32'h0FFFFFFD);
      check_eq("wrap_c17", 32'(trap_vector), 32'h0000040);
      csr_wr(12'h344, 2'b11, 32'h00020000);
      take_irq(); check_eq("cause_16b", 32'(mcause_code), 32'd16);
      check_eq("wrap_c16", 32'(trap_vector), 32'h000003C);
      csr_wr(12'h305, 2'b01, 32'hFFFFFFF1);
      check_eq("wrap_ff1", 32'(trap_vector), 32'h0000030);
      csr_rd(12'h305, rd); check_eq("mtvec_nib7", rd, 32'h0FFFFFF1);

      // Edge vs clear, edge vs take, edge-to-level switch
      timer_irq = 1'b0;
      csr_wr(12'h304, 2'b01, 32'h00030000);
      csr_wr(12'h344, 2'b01, 32'h0);
      csr_xfer(12'h344, 2'b11, 32'h00010000, 4, -1, rd);
      irq_in[0] = 1'b0;
      csr_rd(12'h344, rd); check_eq("set_beats_clr", rd, 32'h00010000);
      csr_wr(12'h344, 2'b11, 32'h00010000);
      align();
      take_interrupt = 1'b1;
      irq_in[1] = 1'b1;
      step();
      take_interrupt = 1'b0;
      #1;
      check_eq("take_edge_cause", 32'(mcause_code), 32'd16);
      check_eq("take_edge_pend", 32'(interrupt_pending), 32'h1);
      irq_in[1] = 1'b0;
      csr_rd(12'h344, rd); check_eq("latch1_held", rd, 32'h00020000);
      csr_wr(12'h7C0, 2'b01, 32'h00000001);
      csr_rd(12'h344, rd); check_eq("to_level_clr", rd, 32'h0);
      csr_wr(12'h7C0, 2'b01, 32'h00000003);
      csr_rd(12'h7C0, rd); check_eq("mtrig_rw", rd, 32'h00000003);
      csr_rd(12'h344, rd); check_eq("to_edge_mip", rd, 32'h0);

      // Reset in the middle of an mie write
      csr_xfer(12'h304, 2'b01, 32'hFFFFFFFF, -1, 5, rd);
      step();
      csr_rd(12'h304, rd); check_eq("midrst_mie", rd, 32'h0);
      csr_rd(12'h305, rd); check_eq("midrst_mtvec", rd, 32'h00000004);
      check_eq("midrst_mcause", 32'(mcause_code), 32'h0);
      check_eq("midrst_pend", 32'(interrupt_pending), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
